// File: rtl/mem_stage_mc_pkg.sv
// Shared types and defaults for the multi-cycle memory stage.
// Holds the FSM state encoding plus default widths and timeout.
package mem_stage_mc_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_TIMEOUT = 15;
  localparam int CTR_W       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_stage_mc_wait_ctr.sv
// Wait counter for outstanding memory accesses; flags when the next
// un-acknowledged BUSY cycle would bring the count up to TIMEOUT.
module mem_wait_ctr
  import mem_stage_mc_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CTR_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + 1'b1;
  end

  // expired is qualified by en, so an ack in the same cycle always wins
  assign expired = en && (count == CTR_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_mc.sv
// Multi-cycle memory stage: issues one load/store at a time and stalls upstream.
// Optional macro MEM_STAGE_ALIGN_CHECK_EN sends odd-address accesses to ERR.
module mem_stage_mc
  import mem_stage_mc_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              halt,
  output logic [DATA_W-1:0] mem_result,
  output logic              stall,
  output logic              err,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic              req_any;
  logic              req_both;
  logic              misaligned;
  logic              start;
  logic              to_err;
  logic              ctr_en;
  logic              expired;

  assign req_any  = mem_read | mem_write;
  assign req_both = mem_read & mem_write;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign misaligned = alu_result[0];
`else
  assign misaligned = 1'b0;
`endif

  assign start  = (state == IDLE) && !halt && req_any && !req_both && !misaligned;
  assign to_err = (state == IDLE) && !halt && req_any && (req_both || misaligned);
  assign ctr_en = (state == BUSY) && !mem_ack;

  mem_wait_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr    (start),
    .en     (ctr_en),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      mem_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_q  <= alu_result;
            wdata_q <= write_data;
            wr_q    <= mem_write;
            state   <= BUSY;
          end else if (to_err) begin
            state <= ERR;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            if (!wr_q)
              mem_result <= mem_rdata;
            state <= DONE;
          end else if (expired) begin
            state <= ERR;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

  // The start cycle stalls combinationally so upstream holds the request operands
  assign stall     = start || (state == BUSY);
  assign mem_req   = (state == BUSY);
  assign err       = (state == ERR);
  assign mem_wr    = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
